sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 103 ++++++++++
 tb/tb_sync_fifo_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with occupancy flags, sticky overflow/underflow
// error flags, and a read port that is either registered or first-word-fall-through.
module sync_fifo_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter bit          FWFT     = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     w_enable,
  input  logic [DATA_W-1:0]        w_data,
  input  logic                     r_enable,
  input  logic                     clear_err,
  output logic [DATA_W-1:0]        r_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       w_ptr;
  logic [AW:0]       r_ptr;
  logic [AW-1:0]     w_idx;
  logic [AW-1:0]     r_idx;
  logic              rd_accept;
  logic              wr_accept;

  assign w_idx = w_ptr[AW-1:0];
  assign r_idx = r_ptr[AW-1:0];

  // The extra pointer MSB makes full and empty distinguishable: the wrapped
  // difference of the two pointers is the occupancy itself.
  assign count        = w_ptr - r_ptr;
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_CNT);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // A pop on a full FIFO frees a slot in the same cycle, so a concurrent push
  // is still accepted; on an empty FIFO the pop is refused and the push is not.
  assign rd_accept = r_enable && !empty;
  assign wr_accept = w_enable && (!full || rd_accept);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      // NOTE: non-blocking updates let every block see pre-edge pointer values.
      if (wr_accept) w_ptr <= w_ptr + PTR_ONE;
      if (rd_accept) r_ptr <= r_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately left without a reset; the pointers alone
  // define which entries are valid, and an unreset array maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[w_idx] <= w_data;
  end

  // Sticky error flags: a new rejection outranks a concurrent clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (w_enable && !wr_accept) || (overflow  && !clear_err);
      underflow <= (r_enable && !rd_accept) || (underflow && !clear_err);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign r_data = empty ? '0 : mem[r_idx];
    end else begin : g_registered
      // The array read sees the pre-edge contents, so a pop of a full FIFO
      // returns the old word even when the concurrent push hits the same slot.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_data <= '0;
        else if (rd_accept) r_data <= mem[r_idx];
      end
    end
  endgenerate

  a_count_bound : assert property (@(posedge clk) disable iff (reset)
    count <= DEPTH_CNT);

  a_full_not_empty : assert property (@(posedge clk) disable iff (reset)
    !(full && empty));

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: registered and FWFT instances share stimulus and
// are compared every cycle against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF_LVL = DEPTH - 2;
  localparam int AE_LVL = 2;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              w_enable  = 1'b0;
  logic [DATA_W-1:0] w_data    = '0;
  logic              r_enable  = 1'b0;
  logic              clear_err = 1'b0;

  logic [DATA_W-1:0] r_data_reg, r_data_fw;
  logic              full_reg, full_fw, empty_reg, empty_fw;
  logic              af_reg, af_fw, ae_reg, ae_fw;
  logic [4:0]        count_reg, count_fw;
  logic              ovf_reg, ovf_fw, unf_reg, unf_fw;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] model_rdata;
  bit                model_ovf;
  bit                model_unf;

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(1'b0)) u_reg (
    .clk(clk), .reset(reset), .w_enable(w_enable), .w_data(w_data),
    .r_enable(r_enable), .clear_err(clear_err), .r_data(r_data_reg),
    .full(full_reg), .empty(empty_reg), .almost_full(af_reg),
    .almost_empty(ae_reg), .count(count_reg), .overflow(ovf_reg),
    .underflow(unf_reg)
  );

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
    .clk(clk), .reset(reset), .w_enable(w_enable), .w_data(w_data),
    .r_enable(r_enable), .clear_err(clear_err), .r_data(r_data_fw),
    .full(full_fw), .empty(empty_fw), .almost_full(af_fw),
    .almost_empty(ae_fw), .count(count_fw), .overflow(ovf_fw),
    .underflow(unf_fw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic compare_all();
    int n;
    logic [DATA_W-1:0] head;
    n    = model_q.size();
    head = (n > 0) ? model_q[0] : '0;
    check("count_reg",  count_reg, n);
    check("count_fw",   count_fw,  n);
    check("full_reg",   full_reg,  n == DEPTH);
    check("full_fw",    full_fw,   n == DEPTH);
    check("empty_reg",  empty_reg, n == 0);
    check("empty_fw",   empty_fw,  n == 0);
    check("af_reg",     af_reg,    n >= AF_LVL);
    check("af_fw",      af_fw,     n >= AF_LVL);
    check("ae_reg",     ae_reg,    n <= AE_LVL);
    check("ae_fw",      ae_fw,     n <= AE_LVL);
    check("ovf_reg",    ovf_reg,   model_ovf);
    check("ovf_fw",     ovf_fw,    model_ovf);
    check("unf_reg",    unf_reg,   model_unf);
    check("unf_fw",     unf_fw,    model_unf);
    check("rdata_reg",  r_data_reg, model_rdata);
    check("rdata_fw",   r_data_fw,  head);
  endtask

  // One clock cycle: drive, advance the model by the FIFO rules, compare.
  task automatic step(input bit we, input logic [DATA_W-1:0] wd,
                      input bit re, input bit clr);
    bit rd_ok, wr_ok;
    w_enable  = we;
    w_data    = wd;
    r_enable  = re;
    clear_err = clr;
    rd_ok = re && (model_q.size() > 0);
    wr_ok = we && ((model_q.size() < DEPTH) || rd_ok);
    @(posedge clk);
    if (rd_ok) model_rdata = model_q.pop_front();
    if (wr_ok) model_q.push_back(wd);
    model_ovf = (we && !wr_ok) || (model_ovf && !clr);
    model_unf = (re && !rd_ok) || (model_unf && !clr);
    #1;
    compare_all();
  endtask

  // Asynchronous reset asserted between edges; effects checked before any edge.
  task automatic pulse_reset();
    w_enable  = 1'b0;
    r_enable  = 1'b0;
    clear_err = 1'b0;
    reset     = 1'b1;
    #1;
    model_q.delete();
    model_rdata = '0;
    model_ovf   = 1'b0;
    model_unf   = 1'b0;
    compare_all();
    check("w_ptr_rst", u_reg.w_ptr, 0);
    check("r_ptr_rst", u_reg.r_ptr, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_rdata = '0;
    model_ovf   = 1'b0;
    model_unf   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;

    // Fill to full, then one rejected write
    for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0);
    check("full_after_fill", full_reg, 1'b1);
    check("count_after_fill", count_reg, 16);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf_17th_write", ovf_reg, 1'b1);
    check("count_stays_16", count_reg, 16);

    // Clear concurrent with a fresh overflow keeps the flag; a lone clear drops it
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    check("ovf_set_wins", ovf_reg, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_cleared", ovf_reg, 1'b0);

    // Drain in order, then one rejected read
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_order", r_data_reg, i);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_extra_read", unf_reg, 1'b1);
    check("rdata_holds_0f", r_data_reg, 8'h0F);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Full FIFO with simultaneous push/pop
    for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    check("full_rw_oldest", r_data_reg, 8'h40);
    check("full_rw_count", count_reg, 16);
    check("full_rw_no_ovf", ovf_reg, 1'b0);
    for (int k = 1; k <= DEPTH; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("a5_16th_read", r_data_reg, 8'hA5);

    // Empty FIFO with simultaneous push/pop
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    check("empty_rw_unf", unf_reg, 1'b1);
    check("empty_rw_count", count_reg, 1);
    check("empty_rw_no_bypass", r_data_reg, 8'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("empty_rw_readback", r_data_reg, 8'h3C);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // FWFT: word visible without a pop, zero once popped
    step(1'b1, 8'h11, 1'b0, 1'b0);
    check("fwft_show", r_data_fw, 8'h11);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_empty", empty_fw, 1'b1);
    check("fwft_zero", r_data_fw, 8'h00);

    // 40 words through with continuous reads (pointer wrap)
    for (int i = 0; i < 40; i++) step(1'b1, DATA_W'(8'h80 + i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("wrap_last", r_data_reg, 8'h80 + 39);

    // Reset mid-transfer at count 7; next write lands at index 0
    for (int i = 0; i < 7; i++) step(1'b1, DATA_W'(8'hC0 + i), 1'b0, 1'b0);
    check("count_before_rst", count_reg, 7);
    pulse_reset();
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    check("post_rst_index0", u_reg.mem[0], 8'h5A);
    check("post_rst_fwft", r_data_fw, 8'h5A);

    // Randomised traffic with phase-varying bias, clears and rare resets
    for (int ph = 0; ph < 16; ph++) begin
      int pw;
      pw = $urandom_range(15, 85);
      for (int s = 0; s < 100; s++) begin
        if ($urandom_range(399) == 0) pulse_reset();
        else step($urandom_range(99) < pw, DATA_W'($urandom),
                  $urandom_range(99) < (100 - pw), $urandom_range(15) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
